// File: rtl/agc_shift_ctrl_if.sv
// Sample/control bus between the sample source, the AGC and the shift stage.
// The master drives samples and controls; the slave (AGC) returns exponent and peak.
interface agc_shift_ctrl_if;
   logic       in_valid;
   logic [7:0] in;
   logic       clear;
   logic       freeze;
   logic [2:0] shift_n;
   logic       shift_upd;
   logic [7:0] peak;

   modport master (
      output in_valid, in, clear, freeze,
      input  shift_n, shift_upd, peak
   );

   modport slave (
      input  in_valid, in, clear, freeze,
      output shift_n, shift_upd, peak
   );
endinterface

// File: rtl/agc_shift_ctrl.sv
// Windowed peak-magnitude AGC that drives the arithmetic right-shift exponent.
// Fast attack to the target exponent, one-step release per completed window.
module agc_shift_ctrl #(
   parameter int WINDOW = 16,
   parameter int LIMIT  = 15
) (
   input logic           clk,
   input logic           rst_n,
   agc_shift_ctrl_if.slave bus
);
   localparam int         CW    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam logic [CW-1:0] LAST = CW'(WINDOW - 1);
   localparam logic [7:0] LIM   = 8'(LIMIT);

   logic [CW-1:0] cnt;
   logic [7:0]    cur_pk;
   logic [7:0]    mag;
   logic [7:0]    pk;
   logic [2:0]    tgt;
   logic          close;

   // -128 negates to 0x80, which reads back as 128 unsigned.
   assign mag   = bus.in[7] ? (~bus.in + 8'd1) : bus.in;
   assign pk    = (mag > cur_pk) ? mag : cur_pk;
   assign close = bus.in_valid && (cnt == LAST);

   // Smallest exponent that brings the peak within the limit; 7 is the floor.
   always_comb begin
      tgt = 3'd7;
      for (int s = 7; s >= 0; s--)
         if ((pk >> s) <= LIM) tgt = 3'(s);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt           <= '0;
         cur_pk        <= '0;
         bus.peak      <= '0;
         bus.shift_n   <= '0;
         bus.shift_upd <= 1'b0;
      end else begin
         bus.shift_upd <= 1'b0;
         if (bus.clear) begin
            cnt    <= '0;
            cur_pk <= '0;
         end else if (close) begin
            cnt      <= '0;
            cur_pk   <= '0;
            bus.peak <= pk;
            if (!bus.freeze) begin
               bus.shift_n   <= (tgt >= bus.shift_n) ? tgt : bus.shift_n - 3'd1;
               bus.shift_upd <= 1'b1;
            end
         end else if (bus.in_valid) begin
            cnt    <= cnt + 1'b1;
            cur_pk <= pk;
         end
      end
   end
endmodule

// File: tb/tb_agc_shift_ctrl.sv
// Directed bench for agc_shift_ctrl with a window-level reference model and
// per-cycle output comparison, plus literal checks on the documented scenarios.
module tb_agc_shift_ctrl;
   localparam int WINDOW = 4;
   localparam int LIMIT  = 15;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   agc_shift_ctrl_if bus();

   agc_shift_ctrl #(.WINDOW(WINDOW), .LIMIT(LIMIT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // Reference model: holds the magnitudes of the open window in a queue.
   int q[$];
   int m_shift = 0, m_peak = 0, m_upd = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         m_shift = 0; m_peak = 0; m_upd = 0;
      end else begin
         m_upd = 0;
         if (bus.clear) q.delete();
         else if (bus.in_valid) begin
            int v;
            v = $signed(bus.in);
            q.push_back(v < 0 ? -v : v);
            if (q.size() == WINDOW) begin
               int pk, s;
               pk = 0;
               foreach (q[i]) if (q[i] > pk) pk = q[i];
               m_peak = pk;
               q.delete();
               if (!bus.freeze) begin
                  s = 0;
                  while (s < 7 && (pk >> s) > LIMIT) s++;
                  m_shift = (s >= m_shift) ? s : m_shift - 1;
                  m_upd = 1;
               end
            end
         end
      end
   end

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("cyc_shift_n", int'(bus.shift_n), m_shift);
      chk("cyc_shift_upd", int'(bus.shift_upd), m_upd);
      chk("cyc_peak", int'(bus.peak), m_peak);
   end

   // Drive at the falling edge, consume one rising edge, return on the next falling edge.
   task automatic sample(input logic [7:0] v, input logic clr = 1'b0);
      bus.in_valid = 1'b1; bus.in = v; bus.clear = clr;
      @(posedge clk); @(negedge clk);
   endtask

   task automatic idle(input int n);
      bus.in_valid = 1'b0; bus.clear = 1'b0;
      repeat (n) begin @(posedge clk); @(negedge clk); end
   endtask

   task automatic lit(input string tag, input int sh, input int up, input int pk);
      chk({tag, "_shift_n"}, int'(bus.shift_n), sh);
      chk({tag, "_upd"}, int'(bus.shift_upd), up);
      chk({tag, "_peak"}, int'(bus.peak), pk);
   endtask

   task automatic window4(input logic [7:0] a, b, c, d);
      sample(a); sample(b); sample(c); sample(d);
   endtask

   initial begin
      int ladder[5] = '{3, 2, 1, 0, 0};
      logic [7:0] tbl[4][4] = '{'{8'hF0, 8'd15, 8'd3, 8'hF9},
                                '{8'd64, 8'hBF, 8'd0, 8'd1},
                                '{8'd127, 8'd0, 8'd0, 8'd0},
                                '{8'd7, 8'hF8, 8'd2, 8'd2}};
      bus.in_valid = 1'b0; bus.in = '0; bus.clear = 1'b0; bus.freeze = 1'b0;
      repeat (2) @(negedge clk);
      lit("reset", 0, 0, 0);
      rst_n = 1'b1;
      idle(1);

      // Attack: 100 needs >>3 to fall under 15.
      window4(8'd100, 8'd2, 8'd2, 8'd2);
      lit("attack", 3, 1, 100);
      idle(1);
      chk("attack_upd_drop", int'(bus.shift_upd), 0);

      // Asynchronous reset mid-window, then a zero window.
      sample(8'd100); sample(8'd100); sample(8'd100);
      bus.in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1 lit("async_rst", 0, 0, 0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      window4(8'd0, 8'd0, 8'd0, 8'd0);
      lit("post_rst", 0, 1, 0);
      idle(1);

      // Extremes: -128 and -1.
      window4(8'h80, 8'd0, 8'd0, 8'd0);
      lit("neg128", 4, 1, 128);
      window4(8'hFF, 8'd0, 8'd0, 8'd0);
      lit("neg1", 3, 1, 1);
      idle(1);

      // Release ladder from 4.
      window4(8'h80, 8'd0, 8'd0, 8'd0);
      foreach (ladder[i]) begin
         window4(8'd0, 8'd0, 8'd0, 8'd0);
         chk("ladder", int'(bus.shift_n), ladder[i]);
      end
      idle(2);

      // Clear discards the same-cycle sample.
      window4(8'h80, 8'd0, 8'd0, 8'd0);
      sample(8'd120); sample(8'd120);
      sample(8'd120, 1'b1);
      window4(8'd1, 8'd1, 8'd1, 8'd1);
      lit("clear", 3, 1, 1);
      idle(1);

      // Freeze with gapped input; then the same unfrozen.
      bus.freeze = 1'b1;
      repeat (4) begin
         sample(8'd90);
         chk("frz_upd", int'(bus.shift_upd), 0);
         idle(1);
         chk("frz_upd", int'(bus.shift_upd), 0);
      end
      lit("freeze", 3, 0, 90);
      bus.freeze = 1'b0;
      repeat (3) begin sample(8'd90); idle(1); end
      sample(8'd90);
      lit("unfreeze", 3, 1, 90);
      idle(1);

      // Assorted windows with gaps, checked by the model only.
      foreach (tbl[w]) begin
         foreach (tbl[w][k]) begin
            sample(tbl[w][k]);
            if (k == 1) idle(2);
         end
      end
      idle(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
